// File: rtl/demux14_pkg.sv
// -----------------------------------------------------------------------------
// demux14_pkg
// Shared constants and enumerations for the demux14_stream 1-to-4 stream
// demultiplexer and its per-channel output slot.
//   CH_NUM       : number of output channels
//   SEL_W        : width of a channel index (select / rotate pointer)
//   mode_e       : MODE_SEL routes by explicit select, MODE_RR by rotating ptr
//   slot_state_e : occupancy of one channel's one-entry output slot
// -----------------------------------------------------------------------------
package demux14_pkg;

  localparam int CH_NUM = 4;
  localparam int SEL_W  = 2;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage : demux14_pkg

// File: rtl/demux_out_slot.sv
// -----------------------------------------------------------------------------
// demux_out_slot
// One channel's one-entry output register with valid/ready handshake.
// A load fills the slot; a drain (valid & ready) empties it unless a load
// arrives in the same cycle, in which case the data is replaced and valid
// stays high so a continuously-ready consumer sees full throughput.
// Ports:
//   i_clk    : rising-edge clock
//   i_rst_n  : asynchronous active-low reset
//   i_load   : write i_data into the slot at the next edge
//   i_data   : beat data to load
//   i_ready  : consumer ready for this channel
//   o_valid  : slot holds a beat not yet taken by the consumer
//   o_y      : slot data (keeps last loaded value after draining)
// -----------------------------------------------------------------------------
module demux_out_slot
  import demux14_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_y
);

  slot_state_e       state_reg, state_next;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg <= SLOT_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  // Data only changes on a load, so it is stable while stalled and keeps
  // its last value once drained.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      data_reg <= '0;
    end else if (i_load) begin
      data_reg <= i_data;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      SLOT_EMPTY: if (i_load)             state_next = SLOT_FULL;
      SLOT_FULL:  if (i_ready && !i_load) state_next = SLOT_EMPTY;
      default:                            state_next = SLOT_EMPTY;
    endcase
  end

  assign o_valid = (state_reg == SLOT_FULL);
  assign o_y     = data_reg;

endmodule : demux_out_slot

// File: rtl/demux14_stream.sv
// -----------------------------------------------------------------------------
// demux14_stream
// 1-to-4 stream demultiplexer with registered outputs. Each accepted input
// beat is routed to one channel chosen either by i_sel (mode 0) or by an
// internal pointer that advances on every accept (mode 1), which splits a
// round-robin muxed stream back into its lanes.
// Optional build macro: DEMUX14_CNT_EN adds per-channel accepted-beat counters
// and the o_cnt_0..o_cnt_3 ports.
// Ports:
//   i_clk, i_rst_n      : clock, asynchronous active-low reset
//   i_mode              : 0 = select by i_sel, 1 = auto-rotate via o_ptr
//   i_sel               : destination channel in mode 0
//   i_valid, i_data     : input beat
//   o_ready             : input beat accepted when i_valid & o_ready
//   o_y_0..o_y_3        : channel output data
//   o_valid[k], i_ready[k] : channel k handshake
//   o_ptr               : current auto-rotate pointer
//   o_cnt_0..o_cnt_3    : accepted-beat counters (DEMUX14_CNT_EN only)
// -----------------------------------------------------------------------------
module demux14_stream
  import demux14_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic [SEL_W-1:0]  i_sel,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic [DATA_W-1:0] o_y_0,
  output logic [DATA_W-1:0] o_y_1,
  output logic [DATA_W-1:0] o_y_2,
  output logic [DATA_W-1:0] o_y_3,
  output logic [CH_NUM-1:0] o_valid,
  input  logic [CH_NUM-1:0] i_ready,
  output logic [SEL_W-1:0]  o_ptr
`ifdef DEMUX14_CNT_EN
  ,
  output logic [CNT_W-1:0]  o_cnt_0,
  output logic [CNT_W-1:0]  o_cnt_1,
  output logic [CNT_W-1:0]  o_cnt_2,
  output logic [CNT_W-1:0]  o_cnt_3
`endif
);

  if (DATA_W < 1 || CNT_W < 1) begin : g_param_check
    $error("demux14_stream: DATA_W and CNT_W must be at least 1");
  end

  logic [SEL_W-1:0]  dst;
  logic [SEL_W-1:0]  ptr_reg, ptr_next;
  logic [CH_NUM-1:0] valid_vec;
  logic [CH_NUM-1:0] load_vec;
  logic [DATA_W-1:0] y_arr [CH_NUM];
  logic              accept;

  assign dst = (mode_e'(i_mode) == MODE_RR) ? ptr_reg : i_sel;

  // The destination slot can take a beat if it is empty or draining this
  // cycle. Gated by reset so nothing is accepted while held in reset.
  assign o_ready = i_rst_n & (~valid_vec[dst] | i_ready[dst]);
  assign accept  = i_valid & o_ready;

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_slot
    assign load_vec[gi] = accept & (dst == SEL_W'(gi));

    demux_out_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_load  (load_vec[gi]),
      .i_data  (i_data),
      .i_ready (i_ready[gi]),
      .o_valid (valid_vec[gi]),
      .o_y     (y_arr[gi])
    );
  end

  // Pointer moves only on accepted beats in rotate mode; a stalled beat or
  // explicit-select traffic leaves it where it is.
  always_comb begin
    ptr_next = ptr_reg;
    if (accept && (mode_e'(i_mode) == MODE_RR)) begin
      ptr_next = ptr_reg + SEL_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

  assign o_ptr   = ptr_reg;
  assign o_valid = valid_vec;
  assign o_y_0   = y_arr[0];
  assign o_y_1   = y_arr[1];
  assign o_y_2   = y_arr[2];
  assign o_y_3   = y_arr[3];

`ifdef DEMUX14_CNT_EN
  logic [CNT_W-1:0] cnt_reg [CH_NUM];

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_cnt
    // Free-running wrap at 2^CNT_W - 1 -> 0.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        cnt_reg[gi] <= '0;
      end else if (load_vec[gi]) begin
        cnt_reg[gi] <= cnt_reg[gi] + CNT_W'(1);
      end
    end
  end

  assign o_cnt_0 = cnt_reg[0];
  assign o_cnt_1 = cnt_reg[1];
  assign o_cnt_2 = cnt_reg[2];
  assign o_cnt_3 = cnt_reg[3];
`endif

endmodule : demux14_stream

// File: doc/demux14_stream.md
Name: demux14_stream

Overview:
- 1-to-4 stream demultiplexer with registered outputs; the inverse of the team's 4:1 mux datapath.
- Routes each accepted input beat to one of four output channels.
- Channel choice is either an explicit select or an internal rotating pointer, so a round-robin muxed stream can be split back into lanes.
- Sits between a shared producer and four independent consumers, each with valid/ready flow control.

Parameters:
- DATA_W, 8, width of the data path on every port.
- CNT_W, 16, width of the per-channel beat counters (used only with the optional feature).

Ports:
- i_clk  input  1  rising-edge clock
- i_rst_n  input  1  asynchronous active-low reset
- i_mode  input  1  0 = explicit select via i_sel, 1 = auto-rotate via internal pointer
- i_sel  input  2  destination channel when i_mode=0
- i_valid  input  1  input beat valid
- i_data  input  DATA_W  input beat data
- o_ready  output  1  input beat accepted this cycle when i_valid & o_ready
- o_y_0..o_y_3  output  DATA_W each  channel output data
- o_valid  output  4  per-channel output valid, bit k = channel k
- i_ready  input  4  per-channel consumer ready, bit k = channel k
- o_ptr  output  2  current auto-rotate pointer
- o_cnt_0..o_cnt_3  output  CNT_W each  accepted-beat counters (DEMUX14_CNT_EN only)

Behaviour:
- Reset is asynchronous on falling i_rst_n and released synchronously on i_clk. Reset values: o_valid=0, all o_y_k=0, o_ptr=0, counters=0. o_ready is combinational and reads 0 while reset is asserted.
- Destination: dst = i_mode ? o_ptr : i_sel.
- Each channel has a one-entry output slot with two states:
  - EMPTY -> FULL on a load.
  - FULL -> EMPTY on drain (o_valid[k] & i_ready[k]) with no load.
  - FULL stays FULL on drain and load in the same cycle: data is replaced and valid stays 1, giving full throughput.
- o_ready = ~o_valid[dst] | i_ready[dst]. It is combinational from i_mode, i_sel, o_ptr and i_ready. It never depends on i_valid.
- Accept = i_valid & o_ready. On accept, slot dst loads i_data at the next edge. Latency is 1 cycle, and o_y_k is stable while o_valid[k]=1 and i_ready[k]=0.
- Only slot dst can load. A stall on dst does not block draining of the other slots.
- Pointer:
  - In mode 1, o_ptr advances by 1 on each accept only, wrapping 3 -> 0.
  - A stalled beat holds o_ptr.
  - In mode 0, o_ptr holds its value.
  - Switching i_mode mid-stream takes effect on the same cycle. o_ptr is not cleared.
- o_y_k keeps the last loaded value after draining. Only o_valid[k] marks validity.
- Simultaneous events: drain of channel j and load of channel k (j != k) in the same cycle are independent.
- Reset mid-operation: all buffered beats are discarded and no output is presented until new accepts.
- i_sel is ignored in mode 1, and i_data is ignored when i_valid=0.

Optional Feature:
- Macro: DEMUX14_CNT_EN.
- Defined:
  - Four CNT_W counters; o_cnt_k increments on each accept routed to channel k.
  - Counters wrap at 2^CNT_W - 1 -> 0 and clear on reset.
- Undefined: o_cnt_0..o_cnt_3 ports and counter logic are absent.

Decomposition:
- Package demux14_pkg:
  - Constants CH_NUM=4 and SEL_W=2.
  - Enum for mode: MODE_SEL=0, MODE_RR=1.
  - Slot state enum: SLOT_EMPTY, SLOT_FULL.
- Sub-module demux_out_slot: one channel's valid/data register with load/drain logic. It is instantiated four times from a generate loop. Top level holds dst decode, o_ready, pointer and counters.

Test Plan:
- Mode 0, i_ready=4'b1111: i_sel sweeps 0,1,2,3 with i_data=0,1,2,3 -> o_y_k=k with o_valid[k]=1 one cycle after each accept, and o_ready=1 throughout.
- Mode 1, i_ready=4'b1111, 8 back-to-back beats with data 4..11 -> channels receive 4,8 / 5,9 / 6,10 / 7,11. o_ptr reads 0,1,2,3,0,1,2,3 and returns to 0.
- Backpressure: mode 0, i_sel=2, i_ready[2]=0, beats 0xA0 then 0xA1 -> 0xA0 held on o_y_2. o_ready=0 for 0xA1 until i_ready[2]=1, then 0xA1 loads the next cycle.
- Isolation: channel 1 stalled and full, i_sel=3 with data 0x33 -> o_ready=1 and o_y_3=0x33, while o_y_1 is unchanged.
- Mode 1 stall: i_ready[0]=0 with slot 0 full -> o_ptr holds 0 and no beat is lost or reordered after release.
- Reset: assert i_rst_n=0 mid-stream with all slots full -> o_valid=0 and o_ptr=0 immediately. With DEMUX14_CNT_EN, counters read 0. After 20 beats in mode 1, o_cnt_k=5 each.
